// File: rtl/qnigma_frame_buf_if.sv
// Stream bundle for the frame buffer: write side in, replay side out.
interface qnigma_frame_buf_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] data_in;
  logic         valid_in;
  logic         error_in;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         last_out;

  modport master (
    output data_in, valid_in, error_in,
    input  data_out, valid_out, last_out
  );

  modport slave (
    input  data_in, valid_in, error_in,
    output data_out, valid_out, last_out
  );
endinterface

// File: rtl/qnigma_frame_buf.sv
// Store-and-forward frame buffer: commits good frames into a circular RAM, drops bad or
// overflowing frames whole, and replays committed frames as contiguous, gap-separated bursts.
module qnigma_frame_buf #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned FRAMES  = 16,
  parameter int unsigned GAP     = 2,
  parameter int unsigned OUT_REG = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  qnigma_frame_buf_if.slave              bus,
  output logic                           drop_pulse,
  output logic [15:0]                    drop_cnt,
  output logic [$clog2(FRAMES+1)-1:0]    frames_pending,
  output logic                           full
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned LW    = $clog2(DEPTH + 1);
  localparam int unsigned FAW   = $clog2(FRAMES);
  localparam int unsigned CW    = $clog2(FRAMES + 1);
  localparam int unsigned GW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GLOAD = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_AFTER  = (GAP > 0) ? S_GAP : S_IDLE;

  logic [W-1:0]   r_mem [DEPTH];
  logic [LW-1:0]  r_desc [FRAMES];

  logic           r_vin_d, r_drop;
  logic [PW-1:0]  r_wr_ptr, r_cm_ptr, r_rd_ptr;
  logic [FAW-1:0] r_dw, r_dr;
  logic [1:0]     r_state, w_state_nxt;
  logic [LW-1:0]  r_cnt;
  logic [GW-1:0]  r_gcnt;
  logic           r_cmd_v, r_cmd_last;
  logic [AW-1:0]  r_cmd_addr;
  logic [W-1:0]   r_ram_q;
  logic           r_ram_v, r_ram_last;
  logic [W-1:0]   r_out_data;
  logic           r_out_valid, r_out_last;

  logic [PW-1:0]  w_used, w_wr_nxt, w_rd_nxt;
  logic           w_room, w_start, w_end, w_desc_full, w_drop_cur;
  logic           w_wr, w_push, w_pop, w_rd, w_rd_last;
  logic [LW-1:0]  w_len;

  assign w_used      = r_wr_ptr - r_rd_ptr;
  assign w_room      = w_used < PW'(DEPTH);
  assign w_start     = bus.valid_in & ~r_vin_d;
  assign w_end       = ~bus.valid_in & r_vin_d;
  assign w_desc_full = frames_pending == CW'(FRAMES);
  assign w_drop_cur  = w_start ? w_desc_full : r_drop;
  assign w_wr        = bus.valid_in & w_room;
  assign w_push      = w_end & ~r_drop;
  assign w_len       = LW'(r_wr_ptr - r_cm_ptr);
  assign w_rd_nxt    = r_rd_ptr + PW'(w_rd);

  // A dropped frame rewinds the write pointer to the last commit point.
  always_comb begin
    w_wr_nxt = r_wr_ptr;
    if (bus.valid_in) begin
      if (w_room) w_wr_nxt = r_wr_ptr + PW'(1);
    end else if (r_vin_d && r_drop) begin
      w_wr_nxt = r_cm_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= bus.data_in;
    if (w_push) r_desc[r_dw] <= w_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vin_d    <= 1'b0;
      r_drop     <= 1'b0;
      r_wr_ptr   <= '0;
      r_cm_ptr   <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
      full       <= 1'b0;
    end else begin
      r_vin_d    <= bus.valid_in;
      r_wr_ptr   <= w_wr_nxt;
      drop_pulse <= 1'b0;
      full       <= (w_wr_nxt - w_rd_nxt) == PW'(DEPTH);
      if (bus.valid_in) begin
        r_drop <= w_drop_cur | ~w_room | bus.error_in;
      end else if (r_vin_d) begin
        r_drop <= 1'b0;
        if (r_drop) begin
          drop_pulse <= 1'b1;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end else begin
          r_cm_ptr <= r_wr_ptr;
        end
      end
    end
  end

  // Length-descriptor FIFO; the occupancy register is the frames_pending output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dw           <= '0;
      r_dr           <= '0;
      frames_pending <= '0;
    end else begin
      if (w_push) r_dw <= r_dw + FAW'(1);
      if (w_pop)  r_dr <= r_dr + FAW'(1);
      frames_pending <= frames_pending + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rd        = 1'b0;
    w_rd_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frames_pending != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        w_rd = 1'b1;
        if (r_cnt == LW'(1)) begin
          w_rd_last   = 1'b1;
          w_state_nxt = S_AFTER;
        end
      end
      S_GAP: begin
        if (r_gcnt == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read command is registered, then the RAM returns data one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_gcnt     <= '0;
      r_cmd_v    <= 1'b0;
      r_cmd_last <= 1'b0;
      r_cmd_addr <= '0;
      r_ram_q    <= '0;
      r_ram_v    <= 1'b0;
      r_ram_last <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_nxt;
      if (w_pop)     r_cnt <= r_desc[r_dr];
      else if (w_rd) r_cnt <= r_cnt - LW'(1);
      if (w_rd_last)              r_gcnt <= GW'(GLOAD);
      else if (r_state == S_GAP)  r_gcnt <= r_gcnt - GW'(1);
      r_cmd_v    <= w_rd;
      r_cmd_last <= w_rd_last;
      r_cmd_addr <= r_rd_ptr[AW-1:0];
      r_ram_q    <= r_cmd_v ? r_mem[r_cmd_addr] : '0;
      r_ram_v    <= r_cmd_v;
      r_ram_last <= r_cmd_last;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        r_out_data  <= r_ram_q;
        r_out_valid <= r_ram_v;
        r_out_last  <= r_ram_last;
      end
    end
  end else begin : g_out_ram
    always_comb begin
      r_out_data  = r_ram_q;
      r_out_valid = r_ram_v;
      r_out_last  = r_ram_last;
    end
  end

  assign bus.data_out  = r_out_data;
  assign bus.valid_out = r_out_valid;
  assign bus.last_out  = r_out_last;
endmodule
